// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-segment scan driver. Characters arrive over valid/ready into a
// shadow frame that is committed to the display buffer only at a frame boundary.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);
    localparam int unsigned CntMax =
        (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] OnLast    = CntW'(REFRESH_DIV - 1);

    typedef enum logic {StBlank, StOn} state_e;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        unique case (code)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    state_e          state_q;
    logic [1:0]      digit_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      wp_q;
    logic            pend_q;
    logic [15:0]     shadow_q;
    logic [15:0]     disp_q;
    logic            disp_valid_q;

    logic       xfer;
    logic       last_char;
    logic       boundary;
    logic       commit;
    logic [1:0] digit_next;

    always_comb begin
        xfer       = char_valid & char_ready;
        last_char  = xfer && (wp_q == 2'd0);
        digit_next = digit_q - 2'd1;
        // Leaving digit 0 means the next BLANK entry is on digit 3: the frame boundary.
        boundary   = (state_q == StOn) && (cnt_q == OnLast) && (digit_q == 2'd0);
        commit     = boundary && pend_q;
    end

    // Write side: shadow fill, pending flag and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= 2'd3;
            pend_q     <= 1'b0;
            shadow_q   <= '0;
            char_ready <= 1'b1;
        end else begin
            if (xfer) begin
                shadow_q[{wp_q, 2'b00} +: 4] <= char_in;
                wp_q                         <= wp_q - 2'd1;
            end
            if (last_char) begin
                pend_q <= 1'b1;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
            char_ready <= last_char ? 1'b0 : !pend_q;
        end
    end

    // Scan FSM with registered anode/segment outputs and commit pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StBlank;
            digit_q      <= 2'd3;
            cnt_q        <= '0;
            an           <= 4'b1111;
            seg          <= 7'b1111111;
            frame_done   <= 1'b0;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            frame_done <= commit;
            unique case (state_q)
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_q <= StOn;
                        cnt_q   <= '0;
                        an      <= disp_valid_q ? ~(4'b0001 << digit_q) : 4'b1111;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StOn: begin
                    if (cnt_q == OnLast) begin
                        state_q <= StBlank;
                        cnt_q   <= '0;
                        digit_q <= digit_next;
                        an      <= 4'b1111;
                        // Segments load on blank entry so they settle before the anode lights.
                        if (commit) begin
                            disp_q       <= shadow_q;
                            disp_valid_q <= 1'b1;
                            seg          <= decode(shadow_q[15:12]);
                        end else if (disp_valid_q) begin
                            seg <= decode(disp_q[{digit_next, 2'b00} +: 4]);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes completed frames, a monitor
// pops them at frame boundaries and checks every cycle of the scan.
module tb_seg7_scan_driver;
    localparam int unsigned RD = 4;
    localparam int unsigned BC = 1;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] char_in = 4'h0;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    seg7_scan_driver #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] chars;
        int          done_edge;
    } frame_t;

    frame_t      frames[$];
    logic [15:0] cur = '0;
    int          cur_n = 0;
    logic [15:0] disp = '0;
    bit          disp_valid = 1'b0;
    int          last_commit = -1000;
    int          c = 0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          xfers = 0;
    int          last_xfer_edge = 0;
    int          race_edge = 0;
    logic [6:0]  dec_tab [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, c);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, c);
    endtask

    task automatic record(input logic [3:0] ch, input int e);
        frame_t f;
        xfers++;
        last_xfer_edge = e;
        cur = {cur[11:0], ch};
        cur_n++;
        if (cur_n == 4) begin
            f.chars = cur;
            f.done_edge = e;
            frames.push_back(f);
            cur_n = 0;
        end
    endtask

    // Offer one character; returns at the negedge before the edge that transfers it.
    task automatic send(input logic [3:0] ch);
        int n;
        n = 0;
        @(negedge clk);
        char_in = ch;
        char_valid = 1'b1;
        while (!char_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (char_ready) record(ch, c + 1);
        else fail_now("send_ready");
    endtask

    task automatic drop();
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        while (frames.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (frames.size() != 0) fail_now("commit_wait");
        repeat (2) @(negedge clk);
    endtask

    // Monitor: cycle position within the frame is derived from edges since reset.
    initial begin
        int          p;
        int          slot;
        int          off;
        bit          exp_fd;
        bit          exp_rdy;
        logic [3:0]  onehot;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic [3:0]  ch;
        frame_t      f;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                c = 0;
            end else if (mon_en) begin
                c++;
                p    = c % FRAME;
                slot = p / SLOT;
                off  = p % SLOT;
                exp_fd = (p == 0) && (frames.size() > 0) && (frames[0].done_edge < c);
                if (exp_fd) begin
                    f = frames.pop_front();
                    disp = f.chars;
                    disp_valid = 1'b1;
                    last_commit = c;
                end
                exp_rdy = !(((frames.size() > 0) && (frames[0].done_edge <= c))
                            || (last_commit == c));
                onehot = 4'b0001 << (3 - slot);
                ch = disp[15 - 4 * slot -: 4];
                exp_an  = (!disp_valid || off < BC) ? 4'hF : ~onehot;
                exp_seg = disp_valid ? dec_tab[ch] : 7'h7F;
                chk("frame_done", frame_done, exp_fd);
                chk("char_ready", char_ready, exp_rdy);
                chk("an", an, exp_an);
                chk("seg", seg, exp_seg);
            end
        end
    end

    initial begin
        int n;
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Asynchronous reset asserted mid-cycle.
        #12 reset = 1'b0;
        #1;
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_ready", char_ready, 1);
        chk("reset_frame_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (40) @(negedge clk);

        // 1435 back-to-back, then E held under backpressure.
        send(4'h1); send(4'h4); send(4'h3); send(4'h5);
        send(4'hE);
        chk("xfer_count", xfers, 5);
        chk("bp_accept_edge", last_xfer_edge, last_commit + 2);
        send(4'h0); send(4'h7); send(4'h2);
        drop();
        wait_commit();

        // A,b,C,d arrive while the previous frame is on the display.
        send(4'hA); send(4'hB); send(4'hC); send(4'hD);
        drop();
        wait_commit();
        repeat (FRAME) @(negedge clk);

        // Random frames with random bubbles.
        for (int fr = 0; fr < 3; fr++) begin
            for (int k = 0; k < 4; k++) begin
                send(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 1) == 1) begin
                    drop();
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            drop();
        end
        wait_commit();
        repeat (FRAME) @(negedge clk);

        // Last character lands exactly on a frame-boundary edge.
        send(4'($urandom_range(0, 15)));
        send(4'($urandom_range(0, 15)));
        send(4'($urandom_range(0, 15)));
        drop();
        while ((c + 2) % FRAME != 0) @(negedge clk);
        send(4'($urandom_range(0, 15)));
        race_edge = last_xfer_edge;
        drop();
        wait_commit();
        chk("race_commit_edge", last_commit, race_edge + FRAME);
        repeat (FRAME) @(negedge clk);

        // Reset mid-scan with a partial frame and a lit digit.
        send(4'h3); send(4'h9);
        drop();
        n = 0;
        while (an == 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (an == 4'hF) fail_now("lit_wait");
        #2;
        reset = 1'b0;
        frames.delete();
        cur_n = 0;
        disp_valid = 1'b0;
        last_commit = -1000;
        #1;
        chk("midreset_an", an, 4'hF);
        chk("midreset_seg", seg, 7'h7F);
        chk("midreset_ready", char_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(4'h8); send(4'h8); send(4'h8); send(4'h8);
        drop();
        wait_commit();
        repeat (FRAME + 2) @(negedge clk);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
